// File: rtl/dcm_multi_pkg.sv
// dcm_pkg: shared constants, the select-field type and the terminal-count
// helper used by the dcm_multi clock divider and its channel sub-module.
//   DCM_PROG_W_DEF  : default width of a channel select field
//   DCM_RST_SEL_DEF : default select loaded into every channel at reset
//   dcm_sel_t       : select field at the default width
//   dcm_half_tc()   : half-period terminal count, 2^sel - 1
package dcm_pkg;

  localparam int DCM_PROG_W_DEF  = 3;
  localparam int DCM_RST_SEL_DEF = 0;

  typedef logic [DCM_PROG_W_DEF-1:0] dcm_sel_t;

  // A half-period lasts 2^sel cycles, so the counter wraps at 2^sel - 1.
  function automatic int unsigned dcm_half_tc(input int unsigned sel);
    return (32'd1 << sel) - 32'd1;
  endfunction

endpackage

// File: rtl/dcm_multi_chan.sv
// dcm_chan: one programmable divider channel of dcm_multi.
// Divides clk by 2^(sel+1) with 50% duty. A new select is held pending and
// applied only at the period boundary (counter at terminal count while the
// output is high), so the output never glitches.
// Optional feature (macro DCM_MULTI_GATE_EN): input en stops the channel at
// its next boundary and holds clk_out/cnt at 0 until en returns.
// Ports:
//   clk, rst  : reference clock, async active-high reset
//   en        : channel run enable (only with DCM_MULTI_GATE_EN)
//   prog_in   : select sampled when update is high
//   update    : load strobe
//   clk_out   : divided output (registered)
//   prog_out  : active select
//   busy      : a pending select has not yet been applied
module dcm_chan
  import dcm_pkg::*;
#(
  parameter int PROG_W  = DCM_PROG_W_DEF,
  parameter int RST_SEL = DCM_RST_SEL_DEF
) (
  input  logic              clk,
  input  logic              rst,
`ifdef DCM_MULTI_GATE_EN
  input  logic              en,
`endif
  input  logic [PROG_W-1:0] prog_in,
  input  logic              update,
  output logic              clk_out,
  output logic [PROG_W-1:0] prog_out,
  output logic              busy
);

  // Largest terminal count is 2^(2^PROG_W - 1) - 1.
  localparam int CNT_W = (1 << PROG_W) - 1;

  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              out_reg, out_next;
  logic [PROG_W-1:0] active_reg, active_next;
  logic [PROG_W-1:0] pend_sel_reg, pend_sel_next;
  logic              pend_valid_reg, pend_valid_next;
  logic              at_tc;
  logic              boundary;

  assign at_tc    = (cnt_reg == CNT_W'(dcm_half_tc(32'(active_reg))));
  // End of the high phase: a full period is complete here.
  assign boundary = at_tc && out_reg;

`ifdef DCM_MULTI_GATE_EN
  logic stopped_reg, stopped_next;
`endif

  always_comb begin
    cnt_next        = cnt_reg;
    out_next        = out_reg;
    active_next     = active_reg;
    pend_sel_next   = pend_sel_reg;
    pend_valid_next = pend_valid_reg;

    if (at_tc) begin
      cnt_next = '0;
      out_next = ~out_reg;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end

    if (boundary) begin
      // A strobe landing on the boundary bypasses the pending register.
      if (update)
        active_next = prog_in;
      else if (pend_valid_reg)
        active_next = pend_sel_reg;
      pend_valid_next = 1'b0;
    end else if (update) begin
      pend_sel_next   = prog_in;
      pend_valid_next = 1'b1;
    end

`ifdef DCM_MULTI_GATE_EN
    stopped_next = stopped_reg;
    if (stopped_reg) begin
      if (!en) begin
        // Parked at cnt=0, out=0; no toggling while disabled.
        cnt_next = cnt_reg;
        out_next = out_reg;
      end else begin
        // Resume: this cycle is the first of a fresh low phase.
        stopped_next = 1'b0;
      end
    end else if (boundary && !en) begin
      stopped_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg        <= '0;
      out_reg        <= 1'b0;
      active_reg     <= PROG_W'(RST_SEL);
      pend_sel_reg   <= '0;
      pend_valid_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      out_reg        <= out_next;
      active_reg     <= active_next;
      pend_sel_reg   <= pend_sel_next;
      pend_valid_reg <= pend_valid_next;
    end
  end

`ifdef DCM_MULTI_GATE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stopped_reg <= 1'b0;
    else
      stopped_reg <= stopped_next;
  end
`endif

  assign clk_out  = out_reg;
  assign prog_out = active_reg;
  assign busy     = pend_valid_reg;

endmodule

// File: rtl/dcm_multi.sv
// dcm_multi: multi-channel programmable clock divider.
// N_CH independent channels divide clk by 2^(sel+1); one extra output
// divides clk by the fixed ratio 2^FIX_LOG2. All outputs are registered
// data signals in the clk domain.
// Optional feature (macro DCM_MULTI_GATE_EN): adds ch_en to stop channels
// cleanly at their period boundary.
// Ports:
//   clk, rst  : reference clock, async active-high reset
//   ch_en     : per-channel run enable (only with DCM_MULTI_GATE_EN)
//   prog_in   : packed selects, channel i at [i*PROG_W +: PROG_W]
//   update    : per-channel load strobe
//   clk_fix   : fixed-ratio divided clock, 50% duty
//   clk_out   : programmable divided clocks
//   prog_out  : active select per channel
//   busy      : per-channel pending-select flag
module dcm_multi
  import dcm_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int PROG_W   = DCM_PROG_W_DEF,
  parameter int RST_SEL  = DCM_RST_SEL_DEF,
  parameter int FIX_LOG2 = 1
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef DCM_MULTI_GATE_EN
  input  logic [N_CH-1:0]        ch_en,
`endif
  input  logic [N_CH*PROG_W-1:0] prog_in,
  input  logic [N_CH-1:0]        update,
  output logic                   clk_fix,
  output logic [N_CH-1:0]        clk_out,
  output logic [N_CH*PROG_W-1:0] prog_out,
  output logic [N_CH-1:0]        busy
);

  // The counter MSB flips exactly when the lower bits are all ones,
  // which is the fixed output itself.
  logic [FIX_LOG2-1:0] fix_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fix_cnt_reg <= '0;
    else
      fix_cnt_reg <= fix_cnt_reg + FIX_LOG2'(1);
  end

  assign clk_fix = fix_cnt_reg[FIX_LOG2-1];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    dcm_chan #(
      .PROG_W  (PROG_W),
      .RST_SEL (RST_SEL)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
`ifdef DCM_MULTI_GATE_EN
      .en       (ch_en[gi]),
`endif
      .prog_in  (prog_in[gi*PROG_W +: PROG_W]),
      .update   (update[gi]),
      .clk_out  (clk_out[gi]),
      .prog_out (prog_out[gi*PROG_W +: PROG_W]),
      .busy     (busy[gi])
    );
  end

endmodule

// File: tb/tb_dcm_multi.sv
module tb_dcm_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ch_en;
  logic [5:0] prog_in;
  logic [1:0] update;
  logic       clk_fix;
  logic [1:0] clk_out;
  logic [5:0] prog_out;
  logic [1:0] busy;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dcm_multi #(
    .N_CH     (2),
    .PROG_W   (3),
    .RST_SEL  (0),
    .FIX_LOG2 (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef DCM_MULTI_GATE_EN
    .ch_en    (ch_en),
`endif
    .prog_in  (prog_in),
    .update   (update),
    .clk_fix  (clk_fix),
    .clk_out  (clk_out),
    .prog_out (prog_out),
    .busy     (busy)
  );

  typedef struct packed {
    logic [1:0]  upd;
    logic [5:0]  prog;
    logic [15:0] n;       // cycles to run with these inputs before checking
    logic [1:0]  e_out;
    logic        e_fix;
    logic [1:0]  e_busy;
    logic [5:0]  e_prog;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [1:0] upd, logic [5:0] prog, int n,
                              logic [1:0] e_out, logic e_fix,
                              logic [1:0] e_busy, logic [5:0] e_prog);
    vec_t v;
    v.upd = upd; v.prog = prog; v.n = 16'(n);
    v.e_out = e_out; v.e_fix = e_fix; v.e_busy = e_busy; v.e_prog = e_prog;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic saw5;
    logic bad;

    // Expected states after each step, counted from reset release (state 0).
    vecs[0]  = mk(2'b00, 6'o00,   1, 2'b11, 1'b1, 2'b00, 6'o00);
    vecs[1]  = mk(2'b00, 6'o00,   1, 2'b00, 1'b0, 2'b00, 6'o00);
    // ch0 -> sel 3
    vecs[2]  = mk(2'b01, 6'o03,   1, 2'b11, 1'b1, 2'b01, 6'o00);
    vecs[3]  = mk(2'b00, 6'o00,   1, 2'b00, 1'b0, 2'b00, 6'o03);
    vecs[4]  = mk(2'b00, 6'o00,   7, 2'b10, 1'b1, 2'b00, 6'o03);
    vecs[5]  = mk(2'b00, 6'o00,   1, 2'b01, 1'b0, 2'b00, 6'o03);
    vecs[6]  = mk(2'b00, 6'o00,   7, 2'b11, 1'b1, 2'b00, 6'o03);
    vecs[7]  = mk(2'b00, 6'o00,   1, 2'b00, 1'b0, 2'b00, 6'o03);
    // ch0 sel 5 then sel 2: last one wins
    vecs[8]  = mk(2'b01, 6'o05,   1, 2'b10, 1'b1, 2'b01, 6'o03);
    vecs[9]  = mk(2'b00, 6'o00,   1, 2'b00, 1'b0, 2'b01, 6'o03);
    vecs[10] = mk(2'b01, 6'o02,   1, 2'b10, 1'b1, 2'b01, 6'o03);
    vecs[11] = mk(2'b00, 6'o00,   4, 2'b10, 1'b1, 2'b01, 6'o03);
    vecs[12] = mk(2'b00, 6'o00,   1, 2'b01, 1'b0, 2'b01, 6'o03);
    vecs[13] = mk(2'b00, 6'o00,   7, 2'b11, 1'b1, 2'b01, 6'o03);
    vecs[14] = mk(2'b00, 6'o00,   1, 2'b00, 1'b0, 2'b00, 6'o02);
    vecs[15] = mk(2'b00, 6'o00,   3, 2'b10, 1'b1, 2'b00, 6'o02);
    vecs[16] = mk(2'b00, 6'o00,   1, 2'b01, 1'b0, 2'b00, 6'o02);
    vecs[17] = mk(2'b00, 6'o00,   3, 2'b11, 1'b1, 2'b00, 6'o02);
    vecs[18] = mk(2'b00, 6'o00,   1, 2'b00, 1'b0, 2'b00, 6'o02);
    // simultaneous: ch0 sel 1, ch1 sel 7
    vecs[19] = mk(2'b11, 6'o71,   1, 2'b10, 1'b1, 2'b11, 6'o02);
    vecs[20] = mk(2'b00, 6'o00,   1, 2'b00, 1'b0, 2'b01, 6'o72);
    vecs[21] = mk(2'b00, 6'o00,   1, 2'b00, 1'b1, 2'b01, 6'o72);
    vecs[22] = mk(2'b00, 6'o00,   1, 2'b01, 1'b0, 2'b01, 6'o72);
    vecs[23] = mk(2'b00, 6'o00,   3, 2'b01, 1'b1, 2'b01, 6'o72);
    vecs[24] = mk(2'b00, 6'o00,   1, 2'b00, 1'b0, 2'b00, 6'o71);
    vecs[25] = mk(2'b00, 6'o00,   1, 2'b00, 1'b1, 2'b00, 6'o71);
    vecs[26] = mk(2'b00, 6'o00,   1, 2'b01, 1'b0, 2'b00, 6'o71);
    vecs[27] = mk(2'b00, 6'o00,   2, 2'b00, 1'b0, 2'b00, 6'o71);
    vecs[28] = mk(2'b00, 6'o00, 117, 2'b00, 1'b1, 2'b00, 6'o71);
    vecs[29] = mk(2'b00, 6'o00,   1, 2'b11, 1'b0, 2'b00, 6'o71);
    vecs[30] = mk(2'b00, 6'o00, 127, 2'b10, 1'b1, 2'b00, 6'o71);
    vecs[31] = mk(2'b00, 6'o00,   1, 2'b01, 1'b0, 2'b00, 6'o71);

    rst = 1'b1; ch_en = 2'b11; prog_in = '0; update = '0;
    tick();
    tick();
    chk("reset clk_out", 32'(clk_out), 32'h0);
    chk("reset clk_fix", 32'(clk_fix), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset prog_out", 32'(prog_out), 32'h0);
    rst = 1'b0;

    saw5 = 1'b0;
    for (int v = 0; v < NV; v++) begin
      update  = vecs[v].upd;
      prog_in = vecs[v].prog;
      for (int c = 0; c < int'(vecs[v].n); c++) begin
        tick();
        update = '0;
        if (prog_out[2:0] == 3'd5) saw5 = 1'b1;
      end
      $display("vec %0d: clk_out=%b clk_fix=%b busy=%b prog_out=%o", v,
               clk_out, clk_fix, busy, prog_out);
      chk($sformatf("vec%0d clk_out", v), 32'(clk_out), 32'(vecs[v].e_out));
      chk($sformatf("vec%0d clk_fix", v), 32'(clk_fix), 32'(vecs[v].e_fix));
      chk($sformatf("vec%0d busy", v), 32'(busy), 32'(vecs[v].e_busy));
      chk($sformatf("vec%0d prog_out", v), 32'(prog_out), 32'(vecs[v].e_prog));
    end
    chk("overwritten sel 5 never applied", 32'(saw5), 32'h0);

    // Pending ch1 select, then reset: pending must be discarded.
    update = 2'b10; prog_in = 6'o31;
    tick();
    update = '0;
    $display("pending ch1: busy=%b prog_out=%o", busy, prog_out);
    chk("pending ch1 busy", 32'(busy), 32'h2);
    chk("pending ch1 prog_out", 32'(prog_out), 32'o71);
    rst = 1'b1;
    #1;
    chk("async reset clk_out", 32'(clk_out), 32'h0);
    chk("async reset clk_fix", 32'(clk_fix), 32'h0);
    chk("async reset busy", 32'(busy), 32'h0);
    chk("async reset prog_out", 32'(prog_out), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    $display("after reset: clk_out=%b clk_fix=%b busy=%b prog_out=%o", clk_out, clk_fix, busy, prog_out);
    chk("post reset clk_out", 32'(clk_out), 32'h3);
    chk("post reset clk_fix", 32'(clk_fix), 32'h1);
    bad = 1'b0;
    for (int c = 0; c < 299; c++) begin
      tick();
      if (busy != 2'b00 || prog_out != 6'o00) bad = 1'b1;
    end
    chk("discarded pending stays unapplied", 32'(bad), 32'h0);
    chk("post reset prog_out", 32'(prog_out), 32'h0);

`ifdef DCM_MULTI_GATE_EN
    // Gate: ch0 at sel 2, drop enable mid-high-phase, then restart.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    update = 2'b01; prog_in = 6'o02;
    tick();
    update = '0;
    tick();
    chk("gate sel applied", 32'(prog_out[2:0]), 32'h2);
    chk("gate low phase", 32'(clk_out[0]), 32'h0);
    repeat (5) tick();
    chk("gate high phase", 32'(clk_out[0]), 32'h1);
    ch_en = 2'b10;
    tick();
    chk("gate high continues 1", 32'(clk_out[0]), 32'h1);
    tick();
    chk("gate high continues 2", 32'(clk_out[0]), 32'h1);
    tick();
    chk("gate stopped low", 32'(clk_out[0]), 32'h0);
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (clk_out[0] != 1'b0) bad = 1'b1;
    end
    chk("gate held low", 32'(bad), 32'h0);
    ch_en = 2'b11;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (clk_out[0] != 1'b0) bad = 1'b1;
    end
    chk("gate fresh low phase", 32'(bad), 32'h0);
    tick();
    $display("gate restart: clk_out=%b", clk_out);
    chk("gate first rise", 32'(clk_out[0]), 32'h1);
    chk("gate ch1 unaffected", 32'(clk_out[1]), 32'(clk_fix));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
